// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass at capture, EX-stage operand forwarding and hazard stall.
// Optional build macro ID_EX_FWD_EN: when defined, EX/MEM and MEM/WB forwarding is enabled and only load-use stalls.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [4:0]        exmem_rd,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_reg_write,
    input  logic [4:0]        memwb_rd,
    input  logic [XLEN-1:0]   memwb_wd,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic              stall_id
);

    logic [XLEN-1:0] ex_rd1_q;
    logic [XLEN-1:0] ex_rd2_q;
    logic [XLEN-1:0] cap_rd1;
    logic [XLEN-1:0] cap_rd2;
    logic            hazard;
    logic            bubble;

    // True when a nonzero destination index matches either ID source index.
    function automatic logic src_match(input logic [4:0] dst,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return (dst != 5'd0) && ((dst == rs1) || (dst == rs2));
    endfunction

    // The register file writes at the edge, so a same-cycle read is stale; take the write data instead.
    always_comb begin
        cap_rd1 = id_rd1;
        cap_rd2 = id_rd2;
        if (id_rs1 == 5'd0)
            cap_rd1 = '0;
        else if (memwb_reg_write && (memwb_rd == id_rs1))
            cap_rd1 = memwb_wd;
        if (id_rs2 == 5'd0)
            cap_rd2 = '0;
        else if (memwb_reg_write && (memwb_rd == id_rs2))
            cap_rd2 = memwb_wd;
    end

`ifdef ID_EX_FWD_EN
    function automatic logic [XLEN-1:0] fwd(input logic [4:0]      rs,
                                            input logic [XLEN-1:0] reg_val);
        logic [XLEN-1:0] val;
        val = reg_val;
        if (rs == 5'd0)
            val = '0;
        else if (exmem_reg_write && (exmem_rd == rs))
            val = exmem_result;
        else if (memwb_reg_write && (memwb_rd == rs))
            val = memwb_wd;
        return val;
    endfunction

    always_comb begin
        hazard  = ex_valid && ex_ctrl[1] && src_match(ex_rd, id_rs1, id_rs2);
        ex_op_a = fwd(ex_rs1, ex_rd1_q);
        ex_op_b = fwd(ex_rs2, ex_rd2_q);
    end
`else
    // Without forwarding, wait until the producer reaches MEM/WB where the capture bypass picks it up.
    always_comb begin
        hazard  = (ex_valid && ex_ctrl[0] && src_match(ex_rd, id_rs1, id_rs2)) ||
                  (exmem_reg_write && src_match(exmem_rd, id_rs1, id_rs2));
        ex_op_a = ex_rd1_q;
        ex_op_b = ex_rd2_q;
    end

    logic unused_fwd;
    assign unused_fwd = ^exmem_result;
`endif

    // Held low during reset so a stall never leaks out while the stage is being cleared.
    assign stall_id = rst && id_valid && !flush && hazard;
    assign bubble   = flush || stall_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
            ex_rd1_q <= '0;
            ex_rd2_q <= '0;
        end else if (bubble) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
            ex_rd1_q <= '0;
            ex_rd2_q <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_pc    <= id_pc;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_rd    <= id_rd;
            ex_imm   <= id_imm;
            ex_ctrl  <= id_ctrl;
            ex_rd1_q <= cap_rd1;
            ex_rd2_q <= cap_rd2;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; covers reset, capture bypass, forwarding, load-use, flush and reset-mid-stall.
// Forwarding-specific expectations follow ID_EX_FWD_EN exactly like the design.
module tb_id_ex_stage;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0]   id_rd1, id_rd2, id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              flush;
    logic              exmem_reg_write;
    logic [4:0]        exmem_rd;
    logic [XLEN-1:0]   exmem_result;
    logic              memwb_reg_write;
    logic [4:0]        memwb_rd;
    logic [XLEN-1:0]   memwb_wd;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0]   ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [XLEN-1:0]   ex_op_a, ex_op_b;
    logic              stall_id;

    int checks   = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q[$];

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wd(memwb_wd),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .stall_id(stall_id)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard compare
    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic idle();
        id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_ctrl = '0; flush = 0;
        exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 0; memwb_rd = '0; memwb_wd = '0;
    endtask

    task automatic set_id(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2,
                          input logic [XLEN-1:0] imm, input logic [CTRL_W-1:0] ctrl);
        id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_ctrl = ctrl;
    endtask

    initial begin
        // Reset with every input high
        rst = 0;
        id_valid = 1; id_pc = '1; id_rs1 = '1; id_rs2 = '1; id_rd = '1;
        id_rd1 = '1; id_rd2 = '1; id_imm = '1; id_ctrl = '1; flush = 1;
        exmem_reg_write = 1; exmem_rd = '1; exmem_result = '1;
        memwb_reg_write = 1; memwb_rd = '1; memwb_wd = '1;
        repeat (3) tick();
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_ex_rd", 32'(ex_rd), 0);
        chk("rst_ex_imm", ex_imm, 0);
        chk("rst_ex_ctrl", 32'(ex_ctrl), 0);
        chk("rst_op_a", ex_op_a, 0);
        chk("rst_op_b", ex_op_b, 0);
        chk("rst_stall", 32'(stall_id), 0);

        // Release; first instruction appears after one edge
        rst = 1;
        idle();
        set_id(32'h100, 5'd1, 5'd2, 5'd4, 32'h11, 32'h22, 32'h7, 8'h01);
        #1;
        chk("pre_edge_valid", 32'(ex_valid), 0);
        tick();
        chk("cap_valid", 32'(ex_valid), 1);
        chk("cap_pc", ex_pc, 32'h100);
        chk("cap_rd", 32'(ex_rd), 4);
        chk("cap_imm", ex_imm, 32'h7);
        chk("cap_ctrl", 32'(ex_ctrl), 32'h01);
        chk("cap_op_a", ex_op_a, 32'h11);
        chk("cap_op_b", ex_op_b, 32'h22);

        // Capture bypass: MEM/WB writes x5 while ID reads x5; rs2=0 stays zero
        set_id(32'h104, 5'd5, 5'd0, 5'd6, 32'h11, 32'h55, 32'h0, 8'h00);
        memwb_reg_write = 1; memwb_rd = 5'd5; memwb_wd = 32'hAB;
        tick();
        idle();
        #1;
        chk("bypass_op_a", ex_op_a, 32'hAB);
        chk("idx0_op_b", ex_op_b, 32'h0);

        // Back-to-back stream, one-cycle latency
        for (int i = 0; i < 4; i++) begin
            set_id(32'h200 + 32'(4 * i), 5'd10, 5'd11, 5'(12 + i), 32'(i), 32'(i + 1), 32'h0, 8'h00);
            exp_q.push_back(32'h200 + 32'(4 * i));
            tick();
            chk("stream_pc", ex_pc, exp_q.pop_front());
        end

        // Flush alone kills the ID instruction
        set_id(32'h300, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 8'h01);
        flush = 1;
        tick();
        idle();
        chk("flush_valid", 32'(ex_valid), 0);
        chk("flush_pc", ex_pc, 0);
        chk("flush_rd", 32'(ex_rd), 0);

        // Load-use: lw x7 in EX, add x8, x7, x1 in ID
        set_id(32'h400, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 8'h03);
        tick();
        chk("lw_in_ex_rd", 32'(ex_rd), 7);
        set_id(32'h404, 5'd7, 5'd1, 5'd8, 32'hDEAD, 32'h1111, 32'h0, 8'h01);
        #1;
        chk("lu_stall", 32'(stall_id), 1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 0);
        chk("lu_bubble_rd", 32'(ex_rd), 0);
        exmem_reg_write = 1; exmem_rd = 5'd7; exmem_result = 32'h5000;
        #1;
`ifdef ID_EX_FWD_EN
        chk("lu_stall_once", 32'(stall_id), 0);
        tick();
        chk("lu_add_pc", ex_pc, 32'h404);
        id_valid = 0;
        exmem_reg_write = 0; exmem_rd = '0;
        memwb_reg_write = 1; memwb_rd = 5'd7; memwb_wd = 32'hCAFE;
        #1;
        chk("lu_fwd_memwb_a", ex_op_a, 32'hCAFE);
        chk("lu_op_b", ex_op_b, 32'h1111);
`else
        chk("lu_stall_exmem", 32'(stall_id), 1);
        tick();
        chk("lu_bubble2_valid", 32'(ex_valid), 0);
        exmem_reg_write = 0; exmem_rd = '0;
        memwb_reg_write = 1; memwb_rd = 5'd7; memwb_wd = 32'hCAFE;
        #1;
        chk("lu_stall_release", 32'(stall_id), 0);
        tick();
        idle();
        #1;
        chk("lu_add_pc", ex_pc, 32'h404);
        chk("lu_bypass_a", ex_op_a, 32'hCAFE);
        chk("lu_op_b", ex_op_b, 32'h1111);
`endif
        idle();
        tick();

        // ALU producer add x2 in EX, dependent sub reading x2 in ID
        set_id(32'h500, 5'd0, 5'd0, 5'd2, 32'h0, 32'h0, 32'h0, 8'h01);
        tick();
        set_id(32'h504, 5'd2, 5'd0, 5'd9, 32'h0BAD, 32'h0, 32'h0, 8'h01);
        #1;
`ifdef ID_EX_FWD_EN
        chk("alu_no_stall", 32'(stall_id), 0);
        tick();
        chk("alu_dep_pc", ex_pc, 32'h504);
        chk("alu_dep_rs1", 32'(ex_rs1), 2);
`else
        chk("alu_stall1", 32'(stall_id), 1);
        tick();
        chk("alu_bubble_valid", 32'(ex_valid), 0);
        exmem_reg_write = 1; exmem_rd = 5'd2; exmem_result = 32'h77;
        #1;
        chk("alu_stall2", 32'(stall_id), 1);
        tick();
        exmem_reg_write = 0; exmem_rd = '0;
        memwb_reg_write = 1; memwb_rd = 5'd2; memwb_wd = 32'h77;
        #1;
        chk("alu_stall_release", 32'(stall_id), 0);
        tick();
        idle();
        #1;
        chk("alu_dep_pc", ex_pc, 32'h504);
        chk("alu_bypass_a", ex_op_a, 32'h77);
`endif
        idle();
        tick();

        // Operand B priority with ex_rs2 = 3
        set_id(32'h600, 5'd0, 5'd3, 5'd10, 32'h0, 32'h33, 32'h0, 8'h00);
        tick();
        idle();
        chk("fwd_ex_rs2", 32'(ex_rs2), 3);
        exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'h100;
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_wd = 32'h200;
        #1;
`ifdef ID_EX_FWD_EN
        chk("fwd_exmem_prio", ex_op_b, 32'h100);
        exmem_rd = 5'd0;
        #1;
        chk("fwd_memwb", ex_op_b, 32'h200);
`else
        chk("nofwd_op_b", ex_op_b, 32'h33);
`endif
        idle();
        set_id(32'h604, 5'd0, 5'd0, 5'd10, 32'h0, 32'h44, 32'h0, 8'h00);
        tick();
        idle();
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'h100;
        memwb_reg_write = 1; memwb_rd = 5'd0; memwb_wd = 32'h200;
        #1;
        chk("fwd_idx0_b", ex_op_b, 32'h0);
        idle();
        tick();

        // Flush and load-use together: one bubble, no stall, no duplicate
        set_id(32'h700, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 8'h03);
        tick();
        set_id(32'h704, 5'd7, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, 8'h01);
        flush = 1;
        #1;
        chk("flush_lu_stall", 32'(stall_id), 0);
        tick();
        idle();
        chk("flush_lu_valid", 32'(ex_valid), 0);
        chk("flush_lu_pc", ex_pc, 0);
        tick();
        chk("flush_lu_no_dup", 32'(ex_valid), 0);

        // Reset in the middle of a stall
        set_id(32'h800, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 8'h03);
        tick();
        set_id(32'h804, 5'd7, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, 8'h01);
        #1;
        chk("rms_stall_before", 32'(stall_id), 1);
        rst = 0;
        #1;
        chk("rms_valid", 32'(ex_valid), 0);
        chk("rms_rd", 32'(ex_rd), 0);
        chk("rms_stall", 32'(stall_id), 0);
        tick();
        rst = 1;
        id_valid = 0;
        tick();
        chk("rms_empty", 32'(ex_valid), 0);

        // Normal capture after recovery
        set_id(32'h900, 5'd1, 5'd2, 5'd3, 32'h9, 32'hA, 32'hB, 8'h01);
        tick();
        idle();
        chk("post_valid", 32'(ex_valid), 1);
        chk("post_pc", ex_pc, 32'h900);
        chk("post_op_a", ex_op_a, 32'h9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
